// File: rtl/lcd_ctrl_q_pkg.sv
// Shared states, timing constants (us) and init-byte encoders
// for the HD44780-class character-LCD controller.
package lcd_ctrl_q_pkg;

    typedef enum logic [1:0] {
        POWERUP,
        INIT,
        IDLE,
        XFER
    } lcd_state_e;

    localparam int T_POWERUP = 500;
    localparam int T_PULSE   = 10;
    localparam int T_NIB_GAP = 1;
    localparam int T_SETUP   = 1;
    localparam int T_E_END   = 14;
    localparam int T_CYCLE   = 50;
    localparam int T_LONG    = 2000;
    localparam int T_W_SHORT = 50;
    localparam int T_W_CLEAR = 2000;
    localparam int T_W_ENTRY = 100;

    function automatic int us2cyc(input int us, input int mhz);
        return us * mhz;
    endfunction

    // cfg = {lines, font, disp_on, cursor, blink, inc_dec, shift}
    function automatic logic [7:0] init_byte(
        input logic [2:0] step,
        input logic       bus4,
        input logic [6:0] cfg
    );
        logic [7:0] b;
        case (step)
            3'd0:    b = 8'h20;
            3'd1:    b = {3'b001, ~bus4, cfg[6], cfg[5], 2'b00};
            3'd2:    b = {5'b00001, cfg[4:2]};
            3'd3:    b = 8'h01;
            default: b = {6'b000001, cfg[1:0]};
        endcase
        return b;
    endfunction

    function automatic int init_wait_us(input logic [2:0] step);
        int w;
        case (step)
            3'd3:    w = T_W_CLEAR;
            3'd4:    w = T_W_ENTRY;
            default: w = T_W_SHORT;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lcd_ctrl_q_fifo.sv
// Synchronous command FIFO; pointers wrap naturally as DEPTH
// is a power of two.
module lcd_cmd_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [WIDTH-1:0]          data_i,
    input  logic                      pop_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk
        $error("lcd_cmd_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/lcd_ctrl_q.sv
// Character-LCD controller: power-up wait, cfg-driven init, then
// queued command/data writes in 8-bit or 4-bit bus mode.
module lcd_ctrl_q #(
    parameter int CLK_MHZ    = 15,
    parameter int BUS_4BIT   = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CBITS      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cfg,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       e,
    output logic       rs,
    output logic       rw,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done
);
    import lcd_ctrl_q_pkg::*;

    typedef logic [CBITS-1:0] cnt_t;

    localparam int   CW        = $clog2(FIFO_DEPTH);
    localparam logic BUS4      = (BUS_4BIT != 0);
    localparam cnt_t PWR_LAST  = cnt_t'(us2cyc(T_POWERUP, CLK_MHZ) - 1);
    localparam cnt_t PULSE_C   = cnt_t'(us2cyc(T_PULSE, CLK_MHZ));
    localparam cnt_t GAP_LAST  = cnt_t'(us2cyc(T_PULSE + T_NIB_GAP, CLK_MHZ) - 1);
    localparam cnt_t SETUP_C   = cnt_t'(us2cyc(T_SETUP, CLK_MHZ));
    localparam cnt_t EEND_C    = cnt_t'(us2cyc(T_E_END, CLK_MHZ));
    localparam cnt_t CYC_LAST  = cnt_t'(us2cyc(T_CYCLE, CLK_MHZ) - 1);
    localparam cnt_t LONG_LAST = cnt_t'(us2cyc(T_LONG, CLK_MHZ) - 1);
    localparam logic [2:0] FIRST_STEP = BUS4 ? 3'd0 : 3'd1;
    localparam logic [CW:0] FULL_CNT  = (CW + 1)'(FIFO_DEPTH);

    if (CBITS < 32 &&
        us2cyc(T_PULSE + T_W_CLEAR, CLK_MHZ) >= (1 << CBITS)) begin : g_chk
        $error("lcd_ctrl_q: CBITS too narrow for CLK_MHZ");
    end

    lcd_state_e  state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic        nib_q, nib_d;
    logic [6:0]  cfg_q, cfg_d;
    logic [9:0]  cmd_q, cmd_d;
    logic        e_q, e_d, rs_q, rs_d, rw_q, rw_d;
    logic [7:0]  dat_q, dat_d;
    logic        busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;

    logic        push, pop, full, empty;
    logic [9:0]  head;
    logic [CW:0] count, count_nx;
    logic [7:0]  ibyte;
    logic        split, last, long_w;

    assign push     = cmd_valid && rdy_q && !full;
    assign count_nx = count + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign rdy_d    = (count_nx != FULL_CNT);
    assign busy_d   = (state_q != IDLE) || !empty;
    assign done_d   = done_q || (state_q == IDLE);

    lcd_cmd_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (cmd_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        step_d  = step_q;
        nib_d   = nib_q;
        cfg_d   = cfg_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        e_d     = 1'b0;
        rs_d    = 1'b0;
        rw_d    = 1'b0;
        dat_d   = 8'h00;
        ibyte   = init_byte(step_q, BUS4, cfg_q);
        split   = BUS4 && (step_q != 3'd0);
        last    = !BUS4 || nib_q;
        long_w  = last && !cmd_q[9] &&
                  (cmd_q[7:0] inside {8'h01, 8'h02, 8'h03});
        unique case (state_q)
            POWERUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    cfg_d   = cfg;
                    step_d  = FIRST_STEP;
                    nib_d   = 1'b0;
                end
            end
            INIT: begin
                if (cnt_q < PULSE_C) begin
                    e_d   = 1'b1;
                    dat_d = !split ? ibyte :
                            nib_q  ? {ibyte[3:0], 4'h0} :
                                     {ibyte[7:4], 4'h0};
                end
                // high nibble of a split byte only needs a short gap
                if (split && !nib_q) begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        nib_d = 1'b1;
                    end
                end else if (cnt_q == cnt_t'(us2cyc(T_PULSE +
                             init_wait_us(step_q), CLK_MHZ) - 1)) begin
                    cnt_d = '0;
                    nib_d = 1'b0;
                    if (step_q == 3'd4) state_d = IDLE;
                    else                step_d  = step_q + 3'd1;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    cmd_d   = head;
                    nib_d   = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                rs_d  = cmd_q[9];
                rw_d  = cmd_q[8];
                dat_d = !BUS4 ? cmd_q[7:0] :
                        nib_q ? {cmd_q[3:0], 4'h0} :
                                {cmd_q[7:4], 4'h0};
                e_d   = (cnt_q >= SETUP_C) && (cnt_q < EEND_C);
                if (cnt_q == (long_w ? LONG_LAST : CYC_LAST)) begin
                    cnt_d = '0;
                    if (last) state_d = IDLE;
                    else      nib_d   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= POWERUP;
            cnt_q   <= '0;
            step_q  <= '0;
            nib_q   <= 1'b0;
            cfg_q   <= '0;
            cmd_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            dat_q   <= 8'h00;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            nib_q   <= nib_d;
            cfg_q   <= cfg_d;
            cmd_q   <= cmd_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            rw_q    <= rw_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign cmd_ready = rdy_q;
    assign e         = e_q;
    assign rs        = rs_q;
    assign rw        = rw_q;
    assign lcd_data  = dat_q;
    assign busy      = busy_q;
    assign init_done = done_q;

endmodule
